// File: rtl/fpu_sig_div_if.sv
// Handshake and operand/result bundle between the mul/div/sqrt controller and the
// significand divider.
interface fpu_sig_div_if #(
  parameter int unsigned MANT_W = 24,
  parameter int unsigned EXP_W  = 10,
  parameter int unsigned EXTRA  = 2
);

  logic                      div_start;
  logic [MANT_W-1:0]         mant_a;
  logic [MANT_W-1:0]         mant_b;
  logic [EXP_W-1:0]          exp_a;
  logic [EXP_W-1:0]          exp_b;
  logic                      div_rdy;
  logic [MANT_W+EXTRA-1:0]   quot;
  logic                      sticky;
  logic [EXP_W-1:0]          exp_q;

  modport master (
    output div_start, mant_a, mant_b, exp_a, exp_b,
    input  div_rdy, quot, sticky, exp_q
  );

  modport slave (
    input  div_start, mant_a, mant_b, exp_a, exp_b,
    output div_rdy, quot, sticky, exp_q
  );

endinterface

// File: rtl/fpu_sig_div.sv
// Iterative radix-2 restoring divider for normalized significands; produces a normalized
// quotient with guard/round bits, a sticky bit and the quotient exponent.
module fpu_sig_div #(
  parameter int unsigned MANT_W = 24,
  parameter int unsigned EXP_W  = 10,
  parameter int unsigned EXTRA  = 2
) (
  input  logic             clk,
  input  logic             reset,
  fpu_sig_div_if.slave     bus
);

  localparam int unsigned QW    = MANT_W + EXTRA;
  localparam int unsigned CNT_W = $clog2(QW + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q;
  logic [MANT_W-1:0] divisor_q;
  logic [MANT_W:0]   rem_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [QW-1:0]     quot_q;
  logic [EXP_W-1:0]  exp_res_q;
  logic              sticky_q;
  logic              rdy_q;

  logic              rem_ge;
  logic [MANT_W:0]   rem_sub;
  logic [MANT_W:0]   rem_next;
  logic              a_ge_b;
  logic [EXP_W-1:0]  exp_diff;
  logic [EXP_W-1:0]  exp_diff_m1;

  always_comb begin
    rem_ge      = 1'b0;
    rem_sub     = '0;
    rem_next    = '0;
    a_ge_b      = 1'b0;
    exp_diff    = '0;
    exp_diff_m1 = '0;

    rem_ge   = rem_q >= {1'b0, divisor_q};
    rem_sub  = rem_ge ? (rem_q - {1'b0, divisor_q}) : rem_q;
    rem_next = rem_sub << 1;

    // Pre-shift the dividend when it is smaller so the quotient lands in [1,2).
    a_ge_b      = bus.mant_a >= bus.mant_b;
    exp_diff    = bus.exp_a - bus.exp_b;
    exp_diff_m1 = exp_diff - EXP_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      divisor_q <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      quot_q    <= '0;
      exp_res_q <= '0;
      sticky_q  <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.div_start) begin
            divisor_q <= bus.mant_b;
            if (a_ge_b) begin
              rem_q     <= {1'b0, bus.mant_a};
              exp_res_q <= exp_diff;
            end else begin
              rem_q     <= {bus.mant_a, 1'b0};
              exp_res_q <= exp_diff_m1;
            end
            quot_q  <= '0;
            cnt_q   <= CNT_W'(QW);
            state_q <= StBusy;
          end
        end

        StBusy: begin
          if (!bus.div_start) begin
            state_q <= StIdle;
          end else begin
            quot_q <= {quot_q[QW-2:0], rem_ge};
            rem_q  <= rem_next;
            cnt_q  <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              sticky_q <= |rem_next;
              rdy_q    <= 1'b1;
              state_q  <= StDone;
            end
          end
        end

        StDone: begin
          // Results stay valid until the controller releases the request.
          if (!bus.div_start) begin
            rdy_q   <= 1'b0;
            state_q <= StIdle;
          end
        end

        default: begin
          rdy_q   <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.div_rdy = rdy_q;
  assign bus.quot    = quot_q;
  assign bus.sticky  = sticky_q;
  assign bus.exp_q   = exp_res_q;

endmodule

// File: tb/tb_fpu_sig_div.sv
// Randomized self-checking bench for fpu_sig_div against an arithmetic quotient model.
module tb_fpu_sig_div;

  localparam int MANT_W = 24;
  localparam int EXP_W  = 10;
  localparam int EXTRA  = 2;
  localparam int QW     = MANT_W + EXTRA;
  localparam int LAT    = 27;
  localparam int TMO    = 100;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fpu_sig_div_if #(.MANT_W(MANT_W), .EXP_W(EXP_W), .EXTRA(EXTRA)) bus ();

  fpu_sig_div #(.MANT_W(MANT_W), .EXP_W(EXP_W), .EXTRA(EXTRA)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Quotient from plain integer division, scaled so the result sits in [1,2).
  function automatic void model(input logic [MANT_W-1:0] a, input logic [MANT_W-1:0] b,
                                input int ea, input int eb, output logic [QW-1:0] q,
                                output logic s, output logic [EXP_W-1:0] e);
    longint unsigned num;
    longint unsigned den;
    den = longint'(b);
    num = (a >= b) ? (longint'(a) << (QW - 1)) : (longint'(a) << QW);
    if (b == 0) begin
      q = '1;
      s = 1'b0;
    end else begin
      q = QW'(num / den);
      s = (num % den) != 0;
    end
    e = EXP_W'(ea - eb - ((a < b) ? 1 : 0));
  endfunction

  // Starts an operation and waits for div_rdy; returns at a negedge with the edge count.
  task automatic do_op(input logic [MANT_W-1:0] a, input logic [MANT_W-1:0] b,
                       input int ea, input int eb, output int lat);
    logic [31:0] r;
    @(negedge clk);
    bus.mant_a    = a;
    bus.mant_b    = b;
    bus.exp_a     = EXP_W'(ea);
    bus.exp_b     = EXP_W'(eb);
    bus.div_start = 1'b1;
    lat = 0;
    while (lat < TMO) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) begin
        r = $urandom;
        bus.mant_a = {1'b1, r[22:0]};
        r = $urandom;
        bus.mant_b = {1'b1, r[22:0]};
        bus.exp_a  = EXP_W'($urandom);
        bus.exp_b  = EXP_W'($urandom);
      end
      if (bus.div_rdy === 1'b1) break;
    end
  endtask

  task automatic end_op();
    bus.div_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.div_start = 1'b1;
    bus.mant_a = 24'hC00000;
    bus.mant_b = 24'h800000;
    bus.exp_a  = 10'd5;
    bus.exp_b  = 10'd1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.div_rdy !== 1'b0) begin
      failures++; $display("FAIL reset_rdy: got %b want 0", bus.div_rdy);
    end
    checks++;
    if (bus.quot !== '0) begin
      failures++; $display("FAIL reset_quot: got %h want 0", bus.quot);
    end
    checks++;
    if (bus.sticky !== 1'b0) begin
      failures++; $display("FAIL reset_sticky: got %b want 0", bus.sticky);
    end
    checks++;
    if (bus.exp_q !== '0) begin
      failures++; $display("FAIL reset_exp: got %h want 0", bus.exp_q);
    end
    bus.div_start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [MANT_W-1:0] va[6];
    logic [MANT_W-1:0] vb[6];
    int                ea[6];
    int                eb[6];
    logic [QW-1:0]     wq[6];
    logic              ws[6];
    logic [EXP_W-1:0]  we[6];
    int lat;
    va = '{24'h800000, 24'hC00000, 24'h800000, 24'h800000, 24'h800000, 24'hFFFFFF};
    vb = '{24'h800000, 24'h800000, 24'hC00000, 24'hC00000, 24'hC00000, 24'h000000};
    ea = '{0, 3, 0, 127, -126, 0};
    eb = '{0, 1, 0, -126, 127, 0};
    wq = '{26'h2000000, 26'h3000000, 26'h2AAAAAA, 26'h2AAAAAA, 26'h2AAAAAA, 26'h3FFFFFF};
    ws = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    we = '{10'h000, 10'h002, 10'h3FF, 10'd252, 10'h302, 10'h000};
    for (int i = 0; i < 6; i++) begin
      do_op(va[i], vb[i], ea[i], eb[i], lat);
      checks++;
      if (lat !== LAT) begin
        failures++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, LAT);
      end
      checks++;
      if (bus.quot !== wq[i]) begin
        failures++; $display("FAIL dir%0d_quot: got %h want %h", i, bus.quot, wq[i]);
      end
      // Sticky is undefined for the illegal zero divisor.
      if (vb[i] != 0) begin
        checks++;
        if (bus.sticky !== ws[i]) begin
          failures++; $display("FAIL dir%0d_sticky: got %b want %b", i, bus.sticky, ws[i]);
        end
        checks++;
        if (bus.exp_q !== we[i]) begin
          failures++; $display("FAIL dir%0d_exp: got %h want %h", i, bus.exp_q, we[i]);
        end
      end
      end_op();
    end
  endtask

  task automatic test_random();
    logic [MANT_W-1:0] a, b;
    logic [31:0]       r;
    int                ea, eb, lat;
    logic [QW-1:0]     q;
    logic              s;
    logic [EXP_W-1:0]  e;
    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      a = {1'b1, r[22:0]};
      r = $urandom;
      b = (i % 8 == 0) ? a : {1'b1, r[22:0]};
      ea = int'($urandom_range(0, 253)) - 126;
      eb = int'($urandom_range(0, 253)) - 126;
      model(a, b, ea, eb, q, s, e);
      do_op(a, b, ea, eb, lat);
      checks++;
      if (lat !== LAT || bus.quot !== q || bus.sticky !== s || bus.exp_q !== e) begin
        failures++;
        $display("FAIL rand%0d a=%h b=%h: got lat=%0d q=%h s=%b e=%h want lat=%0d q=%h s=%b e=%h",
                 i, a, b, lat, bus.quot, bus.sticky, bus.exp_q, LAT, q, s, e);
      end
      end_op();
    end
  endtask

  task automatic test_back_to_back();
    logic [MANT_W-1:0] a, b;
    logic [QW-1:0]     q;
    logic              s;
    logic [EXP_W-1:0]  e;
    int                lat;
    a = 24'hF0F0F0;
    b = 24'hA5A5A5;
    model(a, b, 40, -3, q, s, e);
    do_op(a, b, 40, -3, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.div_rdy !== 1'b1 || bus.quot !== q || bus.sticky !== s || bus.exp_q !== e) begin
        failures++;
        $display("FAIL hold%0d: got rdy=%b q=%h s=%b e=%h want rdy=1 q=%h s=%b e=%h",
                 i, bus.div_rdy, bus.quot, bus.sticky, bus.exp_q, q, s, e);
      end
    end
    end_op();
    checks++;
    if (bus.div_rdy !== 1'b0) begin
      failures++; $display("FAIL release_rdy: got %b want 0", bus.div_rdy);
    end
    checks++;
    if (bus.quot !== q || bus.exp_q !== e) begin
      failures++; $display("FAIL idle_hold: got q=%h e=%h want q=%h e=%h",
                           bus.quot, bus.exp_q, q, e);
    end
    a = 24'h9ABCDE;
    b = 24'hFEDCBA;
    model(a, b, -7, 9, q, s, e);
    do_op(a, b, -7, 9, lat);
    checks++;
    if (lat !== LAT || bus.quot !== q || bus.sticky !== s || bus.exp_q !== e) begin
      failures++;
      $display("FAIL restart: got lat=%0d q=%h s=%b e=%h want lat=%0d q=%h s=%b e=%h",
               lat, bus.quot, bus.sticky, bus.exp_q, LAT, q, s, e);
    end
    end_op();
  endtask

  task automatic test_abort();
    logic              saw_rdy;
    logic [MANT_W-1:0] a, b;
    logic [QW-1:0]     q;
    logic              s;
    logic [EXP_W-1:0]  e;
    int                lat;
    // Drop the request part-way through.
    @(negedge clk);
    bus.mant_a = 24'hD00000;
    bus.mant_b = 24'h900000;
    bus.exp_a  = 10'd4;
    bus.exp_b  = 10'd2;
    bus.div_start = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    bus.div_start = 1'b0;
    saw_rdy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.div_rdy !== 1'b0) saw_rdy = 1'b1;
    end
    checks++;
    if (saw_rdy !== 1'b0) begin
      failures++; $display("FAIL abort_rdy: got %b want 0", saw_rdy);
    end
    a = 24'hB33333;
    b = 24'hC44444;
    model(a, b, 1, 1, q, s, e);
    do_op(a, b, 1, 1, lat);
    checks++;
    if (lat !== LAT || bus.quot !== q || bus.sticky !== s || bus.exp_q !== e) begin
      failures++;
      $display("FAIL after_abort: got lat=%0d q=%h s=%b e=%h want lat=%0d q=%h s=%b e=%h",
               lat, bus.quot, bus.sticky, bus.exp_q, LAT, q, s, e);
    end
    end_op();
    // Reset mid-operation clears everything.
    @(negedge clk);
    bus.mant_a = 24'h812345;
    bus.mant_b = 24'hF00001;
    bus.div_start = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.div_rdy !== 1'b0 || bus.quot !== '0 || bus.sticky !== 1'b0 || bus.exp_q !== '0) begin
      failures++;
      $display("FAIL reset_abort: got rdy=%b q=%h s=%b e=%h want all zero",
               bus.div_rdy, bus.quot, bus.sticky, bus.exp_q);
    end
    bus.div_start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    a = 24'hFFFFFF;
    b = 24'h800001;
    model(a, b, -126, -126, q, s, e);
    do_op(a, b, -126, -126, lat);
    checks++;
    if (lat !== LAT || bus.quot !== q || bus.sticky !== s || bus.exp_q !== e) begin
      failures++;
      $display("FAIL after_reset: got lat=%0d q=%h s=%b e=%h want lat=%0d q=%h s=%b e=%h",
               lat, bus.quot, bus.sticky, bus.exp_q, LAT, q, s, e);
    end
    end_op();
  endtask

  initial begin
    reset         = 1'b1;
    bus.div_start = 1'b0;
    bus.mant_a    = '0;
    bus.mant_b    = '0;
    bus.exp_a     = '0;
    bus.exp_b     = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation time limit");
  end

endmodule
